// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared constants, Booth digit type and the radix-4 digit
//                encoder used by the partial-product generator.
//                  A_W    - multiplicand width (16)
//                  B_W    - multiplier width (16)
//                  PP_W   - partial-product width (32)
//                  NUM_PP - number of partial products / Booth digits (8)
//  Revision    : 1.0 - initial release
// ============================================================================
package booth_pkg;

   localparam int A_W    = 16;
   localparam int B_W    = 16;
   localparam int PP_W   = 32;
   localparam int NUM_PP = 8;

   typedef enum logic [2:0] {
      DIG_ZERO = 3'd0,
      DIG_P1   = 3'd1,
      DIG_P2   = 3'd2,
      DIG_M1   = 3'd3,
      DIG_M2   = 3'd4
   } booth_dig_t;

   // Triplet is {b[2k+1], b[2k], b[2k-1]}.
   function automatic booth_dig_t booth_encode(input logic [2:0] triplet);
      booth_dig_t dig;
      case (triplet)
         3'b001, 3'b010: dig = DIG_P1;
         3'b011:         dig = DIG_P2;
         3'b100:         dig = DIG_M2;
         3'b101, 3'b110: dig = DIG_M1;
         default:        dig = DIG_ZERO;
      endcase
      return dig;
   endfunction

endpackage : booth_pkg
`default_nettype wire

// File: rtl/booth_pp_row.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pp_row
//  Description : One partial-product row (combinational). Scales the
//                sign-extended multiplicand by the Booth digit and shifts it
//                into its column position 2*K.
//  Ports       : a   - signed multiplicand
//                dig - Booth digit for this row
//                pp  - pre-shifted two's complement partial product
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_row
   import booth_pkg::*;
#(
   parameter int K = 0
) (
   input  logic [A_W-1:0]  a,
   input  booth_dig_t      dig,
   output logic [PP_W-1:0] pp
);

   logic [PP_W-1:0] w_a_sext;
   logic [PP_W-1:0] w_mag;

   assign w_a_sext = {{(PP_W-A_W){a[A_W-1]}}, a};

   // Negation is a full two's complement in the row, so the summed rows
   // need no separate correction bits. -2 * (-32768) = +65536 fits easily.
   always_comb begin
      w_mag = '0;
      case (dig)
         DIG_P1:  w_mag = w_a_sext;
         DIG_P2:  w_mag = w_a_sext << 1;
         DIG_M1:  w_mag = -w_a_sext;
         DIG_M2:  w_mag = -(w_a_sext << 1);
         default: w_mag = '0;
      endcase
   end

   assign pp = w_mag << (2 * K);

endmodule : booth_pp_row
`default_nettype wire

// File: rtl/booth_pp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pp_gen
//  Description : Radix-4 Booth partial-product generator for the 16x16
//                signed multiplier. Two pipeline stages with valid/ready on
//                both sides:
//                  S1 - multiplicand, 8 encoded Booth digits, tag
//                  S2 - pp0..pp7, tag
//  Ports       : clk, rst_n          - clock, async active-low reset
//                in_valid/in_ready   - operand handshake
//                in_a, in_b, in_tag  - signed operands and opaque tag
//                out_valid/out_ready - partial-product handshake
//                pp0..pp7, out_tag   - pre-shifted partial products and tag
//  Revision    : 1.0 - initial release
// ============================================================================
module booth_pp_gen #(
   parameter int A_W   = 16,
   parameter int B_W   = 16,
   parameter int PP_W  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [A_W-1:0]   in_a,
   input  logic [B_W-1:0]   in_b,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PP_W-1:0]  pp0,
   output logic [PP_W-1:0]  pp1,
   output logic [PP_W-1:0]  pp2,
   output logic [PP_W-1:0]  pp3,
   output logic [PP_W-1:0]  pp4,
   output logic [PP_W-1:0]  pp5,
   output logic [PP_W-1:0]  pp6,
   output logic [PP_W-1:0]  pp7,
   output logic [TAG_W-1:0] out_tag
);

   import booth_pkg::*;

   // ------------------------------------------------------------------------
   // Handshake: each stage may load when it is empty or its consumer drains
   // it this cycle. out_ready reaches in_ready combinationally, in_valid
   // never reaches out_valid.
   // ------------------------------------------------------------------------
   logic w_s1_adv;
   logic w_s2_adv;
   logic r_s1_valid;
   logic r_s2_valid;

   assign w_s2_adv = !r_s2_valid || out_ready;
   assign w_s1_adv = !r_s1_valid || w_s2_adv;
   assign in_ready = w_s1_adv;

   // ------------------------------------------------------------------------
   // Digit encoders on the input side. Appending a zero below the LSB gives
   // the implicit b[-1] = 0, so digit k is bits [2k+2:2k] of the extension.
   // ------------------------------------------------------------------------
   logic [B_W:0] w_b_ext;
   booth_dig_t   w_dig [NUM_PP];

   assign w_b_ext = {in_b, 1'b0};

   generate
      for (genvar k = 0; k < NUM_PP; k++) begin : g_enc
         assign w_dig[k] = booth_encode(w_b_ext[2*k +: 3]);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Stage 1
   // ------------------------------------------------------------------------
   logic [A_W-1:0]   r_s1_a;
   booth_dig_t       r_s1_dig [NUM_PP];
   logic [TAG_W-1:0] r_s1_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= '0;
         r_s1_tag   <= '0;
         for (int k = 0; k < NUM_PP; k++) begin
            r_s1_dig[k] <= DIG_ZERO;
         end
      end else if (w_s1_adv) begin
         r_s1_valid <= in_valid;
         if (in_valid) begin
            r_s1_a   <= in_a;
            r_s1_tag <= in_tag;
            for (int k = 0; k < NUM_PP; k++) begin
               r_s1_dig[k] <= w_dig[k];
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Row generators between the stages
   // ------------------------------------------------------------------------
   logic [PP_W-1:0] w_pp [NUM_PP];

   generate
      for (genvar k = 0; k < NUM_PP; k++) begin : g_row
         booth_pp_row #(
            .K (k)
         ) u_row (
            .a   (r_s1_a),
            .dig (r_s1_dig[k]),
            .pp  (w_pp[k])
         );
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Stage 2: only loads when it may advance, so a stalled set is held
   // bit-stable on the outputs.
   // ------------------------------------------------------------------------
   logic [PP_W-1:0]  r_s2_pp [NUM_PP];
   logic [TAG_W-1:0] r_s2_tag;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s2_valid <= 1'b0;
         r_s2_tag   <= '0;
         for (int k = 0; k < NUM_PP; k++) begin
            r_s2_pp[k] <= '0;
         end
      end else if (w_s2_adv) begin
         r_s2_valid <= r_s1_valid;
         if (r_s1_valid) begin
            r_s2_tag <= r_s1_tag;
            for (int k = 0; k < NUM_PP; k++) begin
               r_s2_pp[k] <= w_pp[k];
            end
         end
      end
   end

   assign out_valid = r_s2_valid;
   assign out_tag   = r_s2_tag;
   assign pp0       = r_s2_pp[0];
   assign pp1       = r_s2_pp[1];
   assign pp2       = r_s2_pp[2];
   assign pp3       = r_s2_pp[3];
   assign pp4       = r_s2_pp[4];
   assign pp5       = r_s2_pp[5];
   assign pp6       = r_s2_pp[6];
   assign pp7       = r_s2_pp[7];

endmodule : booth_pp_gen
`default_nettype wire
